// File: rtl/drive_pkg.sv
// Shared encodings for the drive arbiter: motor directions, IR key codes, FSM states
// and the key-code classification helpers used by the FSM.
package drive_pkg;

    typedef enum logic [2:0] {
        DirStop  = 3'd0,
        DirFwd   = 3'd1,
        DirBack  = 3'd2,
        DirLeft  = 3'd3,
        DirRight = 3'd4
    } dir_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StManual = 3'd1,
        StTrack  = 3'd2,
        StSearch = 3'd3,
        StHalt   = 3'd4
    } state_e;

    localparam logic [7:0] IrAuto  = 8'h01;
    localparam logic [7:0] IrFwd   = 8'h02;
    localparam logic [7:0] IrLeft  = 8'h04;
    localparam logic [7:0] IrStop  = 8'h05;
    localparam logic [7:0] IrRight = 8'h06;
    localparam logic [7:0] IrBack  = 8'h08;

    localparam logic [1:0] SearchSpeed = 2'd1;

    function automatic logic ir_is_move(input logic [7:0] code);
        return (code == IrFwd) || (code == IrBack) || (code == IrLeft) || (code == IrRight);
    endfunction

    function automatic dir_e ir_to_dir(input logic [7:0] code);
        dir_e d;
        d = DirStop;
        case (code)
            IrFwd:   d = DirFwd;
            IrBack:  d = DirBack;
            IrLeft:  d = DirLeft;
            IrRight: d = DirRight;
            default: d = DirStop;
        endcase
        return d;
    endfunction

    // Camera codes 5..7 have no meaning and are treated as a stop request.
    function automatic dir_e sanitize_dir(input logic [2:0] raw);
        return (raw > 3'd4) ? DirStop : dir_e'(raw);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that saturates at zero; o_expired is high whenever the count is zero.
module hold_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    output logic             o_expired
);

    logic [Width-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - Width'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/drive_arbiter.sv
// Motor command arbiter: chooses between IR remote, camera tracking and a timed search sweep,
// and presents one registered direction/speed pair with a change strobe.
module drive_arbiter
    import drive_pkg::*;
#(
    parameter int unsigned MANUAL_HOLD = 25_000_000,
    parameter int unsigned LOST_HOLD   = 12_500_000
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       ir_valid,
    input  logic [7:0] ir_button,
    input  logic [2:0] cam_direction,
    input  logic       orange_detected,
    input  logic [1:0] speed,
    output logic [2:0] motor_dir,
    output logic [1:0] motor_speed,
    output logic       cmd_valid,
    output logic [2:0] state,
    output logic       auto_en
);

    localparam int unsigned CntW = cnt_width(MANUAL_HOLD, LOST_HOLD);
    localparam logic [CntW-1:0] ManLoad  = CntW'(MANUAL_HOLD - 1);
    localparam logic [CntW-1:0] LostLoad = CntW'(LOST_HOLD - 1);

    state_e     r_state;
    dir_e       r_dir;
    logic [1:0] r_spd;
    logic       r_cmd_valid;
    logic       r_auto_en;
    dir_e       r_man_dir;

    state_e     w_state_d;
    dir_e       w_dir_d;
    logic [1:0] w_spd_d;
    logic       w_auto_d;
    dir_e       w_man_dir_d;
    logic       w_ir_stop;
    logic       w_ir_move;
    logic       w_ir_auto;
    logic       w_man_exp;
    logic       w_lost_exp;
    logic       w_man_load;
    logic       w_lost_load;

    assign w_ir_stop = ir_valid && (ir_button == IrStop);
    assign w_ir_move = ir_valid && ir_is_move(ir_button);
    assign w_ir_auto = ir_valid && (ir_button == IrAuto);

    hold_timer #(
        .Width (CntW)
    ) u_manual_timer (
        .i_clk      (clk_50),
        .i_reset    (reset),
        .i_load     (w_man_load),
        .i_load_val (ManLoad),
        .o_expired  (w_man_exp)
    );

    hold_timer #(
        .Width (CntW)
    ) u_lost_timer (
        .i_clk      (clk_50),
        .i_reset    (reset),
        .i_load     (w_lost_load),
        .i_load_val (LostLoad),
        .o_expired  (w_lost_exp)
    );

    // Events are taken in strict priority: STOP, movement, AUTO, timer expiry, target change.
    always_comb begin
        w_state_d   = r_state;
        w_auto_d    = r_auto_en;
        w_man_dir_d = r_man_dir;
        if (w_ir_stop) begin
            w_state_d = StHalt;
        end else if (w_ir_move) begin
            w_state_d   = StManual;
            w_man_dir_d = ir_to_dir(ir_button);
        end else if (w_ir_auto) begin
            w_auto_d = !r_auto_en;
            case (r_state)
                StIdle, StHalt: begin
                    if (w_auto_d) w_state_d = orange_detected ? StTrack : StSearch;
                    else          w_state_d = StIdle;
                end
                StTrack, StSearch: begin
                    if (!w_auto_d) w_state_d = StIdle;
                end
                default: ;
            endcase
        end else begin
            case (r_state)
                StManual: begin
                    if (w_man_exp) begin
                        if (r_auto_en) w_state_d = orange_detected ? StTrack : StSearch;
                        else           w_state_d = StIdle;
                    end
                end
                StTrack: begin
                    if (!orange_detected) w_state_d = StSearch;
                end
                StSearch: begin
                    if (w_lost_exp)           w_state_d = StIdle;
                    else if (orange_detected) w_state_d = StTrack;
                end
                StIdle: begin
                    if (r_auto_en && orange_detected) w_state_d = StTrack;
                end
                default: ;
            endcase
        end
    end

    assign w_man_load = w_ir_move;
    // Every entry into SEARCH starts a fresh search window, whatever the source state.
    assign w_lost_load = (w_state_d == StSearch) && (r_state != StSearch);

    always_comb begin
        w_dir_d = DirStop;
        w_spd_d = '0;
        case (w_state_d)
            StManual: begin
                w_dir_d = w_man_dir_d;
                w_spd_d = speed;
            end
            StTrack: begin
                w_dir_d = sanitize_dir(cam_direction);
                w_spd_d = speed;
            end
            StSearch: begin
                w_dir_d = DirRight;
                w_spd_d = SearchSpeed;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state     <= StIdle;
            r_dir       <= DirStop;
            r_spd       <= '0;
            r_cmd_valid <= 1'b0;
            r_auto_en   <= 1'b0;
            r_man_dir   <= DirStop;
        end else begin
            r_state     <= w_state_d;
            r_dir       <= w_dir_d;
            r_spd       <= w_spd_d;
            r_cmd_valid <= (w_dir_d != r_dir) || (w_spd_d != r_spd);
            r_auto_en   <= w_auto_d;
            r_man_dir   <= w_man_dir_d;
        end
    end

    assign motor_dir   = r_dir;
    assign motor_speed = r_spd;
    assign cmd_valid   = r_cmd_valid;
    assign state       = r_state;
    assign auto_en     = r_auto_en;

endmodule

// File: tb/tb_drive_arbiter.sv
// Bench for drive_arbiter: a vector table, directed timing sequences, and a randomized run
// checked against a timestamp-based reference model.
module tb_drive_arbiter;

    localparam int ManHold  = 10;
    localparam int LostHold = 8;

    localparam int SIdle   = 0;
    localparam int SManual = 1;
    localparam int STrack  = 2;
    localparam int SSearch = 3;
    localparam int SHalt   = 4;

    logic       clk_50 = 1'b0;
    logic       reset;
    logic       ir_valid;
    logic [7:0] ir_button;
    logic [2:0] cam_direction;
    logic       orange_detected;
    logic [1:0] speed;
    logic [2:0] motor_dir;
    logic [1:0] motor_speed;
    logic       cmd_valid;
    logic [2:0] state;
    logic       auto_en;

    int total = 0;
    int bad   = 0;

    drive_arbiter #(
        .MANUAL_HOLD (ManHold),
        .LOST_HOLD   (LostHold)
    ) dut (
        .clk_50          (clk_50),
        .reset           (reset),
        .ir_valid        (ir_valid),
        .ir_button       (ir_button),
        .cam_direction   (cam_direction),
        .orange_detected (orange_detected),
        .speed           (speed),
        .motor_dir       (motor_dir),
        .motor_speed     (motor_speed),
        .cmd_valid       (cmd_valid),
        .state           (state),
        .auto_en         (auto_en)
    );

    always #10 clk_50 = ~clk_50;

    typedef struct {
        logic       iv;
        logic [7:0] btn;
        logic [2:0] cam;
        logic       org;
        logic [1:0] spd;
        logic [2:0] e_st;
        logic [2:0] e_dir;
        logic [1:0] e_spd;
        logic       e_cv;
        logic       e_auto;
    } vec_t;

    vec_t tv[16];
    logic [7:0] codes[10];

    // Reference model: hold windows tracked as absolute edge deadlines.
    int cyc = 0;
    int man_dl = 0;
    int lost_dl = 0;
    int m_st, m_auto, m_mdir, m_dir, m_spd, m_cv;

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic iv, input logic [7:0] btn, input logic [2:0] cam,
                          input logic org, input logic [1:0] spd);
        ir_valid        = iv;
        ir_button       = btn;
        cam_direction   = cam;
        orange_detected = org;
        speed           = spd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b0, 8'h00, 3'd0, 1'b0, 2'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic int move_dir(input logic [7:0] b);
        case (b)
            8'h02:   return 1;
            8'h08:   return 2;
            8'h04:   return 3;
            8'h06:   return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int prev;
        int nd;
        int ns;
        cyc++;
        if (reset) begin
            m_st = SIdle; m_auto = 0; m_mdir = 0; m_dir = 0; m_spd = 0; m_cv = 0;
            return;
        end
        prev = m_st;
        if (ir_valid && ir_button == 8'h05) begin
            m_st = SHalt;
        end else if (ir_valid && move_dir(ir_button) != 0) begin
            m_st = SManual;
            m_mdir = move_dir(ir_button);
            man_dl = cyc + ManHold;
        end else if (ir_valid && ir_button == 8'h01) begin
            m_auto = 1 - m_auto;
            if (m_st == SIdle || m_st == SHalt)
                m_st = (m_auto == 0) ? SIdle : (orange_detected ? STrack : SSearch);
            else if (m_st != SManual && m_auto == 0)
                m_st = SIdle;
        end else if (m_st == SManual) begin
            if (cyc >= man_dl) m_st = (m_auto == 0) ? SIdle : (orange_detected ? STrack : SSearch);
        end else if (m_st == SSearch) begin
            if (cyc >= lost_dl) m_st = SIdle;
            else if (orange_detected) m_st = STrack;
        end else if (m_st == STrack) begin
            if (!orange_detected) m_st = SSearch;
        end else if (m_st == SIdle) begin
            if (m_auto == 1 && orange_detected) m_st = STrack;
        end
        if (m_st == SSearch && prev != SSearch) lost_dl = cyc + LostHold;
        nd = 0;
        ns = 0;
        if (m_st == SManual) begin
            nd = m_mdir; ns = int'(speed);
        end else if (m_st == STrack) begin
            nd = (cam_direction > 3'd4) ? 0 : int'(cam_direction); ns = int'(speed);
        end else if (m_st == SSearch) begin
            nd = 4; ns = 1;
        end
        m_cv = (nd != m_dir || ns != m_spd) ? 1 : 0;
        m_dir = nd;
        m_spd = ns;
    endtask

    initial begin
        //          iv    btn    cam   org   spd   st    dir   spd   cv    auto
        tv[0]  = '{1'b1, 8'h02, 3'd0, 1'b0, 2'd2, 3'd1, 3'd1, 2'd2, 1'b1, 1'b0};
        tv[1]  = '{1'b0, 8'h00, 3'd0, 1'b0, 2'd2, 3'd1, 3'd1, 2'd2, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 8'h03, 3'd0, 1'b0, 2'd2, 3'd1, 3'd1, 2'd2, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 8'h04, 3'd0, 1'b0, 2'd2, 3'd1, 3'd3, 2'd2, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 8'h00, 3'd0, 1'b0, 2'd3, 3'd1, 3'd3, 2'd3, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 8'h05, 3'd0, 1'b0, 2'd3, 3'd4, 3'd0, 2'd0, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 8'h03, 3'd0, 1'b0, 2'd3, 3'd4, 3'd0, 2'd0, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 8'h00, 3'd0, 1'b1, 2'd3, 3'd4, 3'd0, 2'd0, 1'b0, 1'b0};
        tv[8]  = '{1'b1, 8'h01, 3'd3, 1'b1, 2'd1, 3'd2, 3'd3, 2'd1, 1'b1, 1'b1};
        tv[9]  = '{1'b0, 8'h00, 3'd7, 1'b1, 2'd1, 3'd2, 3'd0, 2'd1, 1'b1, 1'b1};
        tv[10] = '{1'b0, 8'h00, 3'd4, 1'b0, 2'd2, 3'd3, 3'd4, 2'd1, 1'b1, 1'b1};
        tv[11] = '{1'b0, 8'h00, 3'd2, 1'b1, 2'd2, 3'd2, 3'd2, 2'd2, 1'b1, 1'b1};
        tv[12] = '{1'b1, 8'h01, 3'd2, 1'b1, 2'd2, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0};
        tv[13] = '{1'b1, 8'h08, 3'd2, 1'b1, 2'd1, 3'd1, 3'd2, 2'd1, 1'b1, 1'b0};
        tv[14] = '{1'b1, 8'h06, 3'd2, 1'b1, 2'd1, 3'd1, 3'd4, 2'd1, 1'b1, 1'b0};
        tv[15] = '{1'b1, 8'h01, 3'd2, 1'b1, 2'd1, 3'd1, 3'd4, 2'd1, 1'b0, 1'b1};
        codes = '{8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h08, 8'h03, 8'h00, 8'hff, 8'h02};

        do_reset();
        check("reset_state", int'(state), SIdle);
        check("reset_dir", int'(motor_dir), 0);
        check("reset_speed", int'(motor_speed), 0);
        check("reset_cmd_valid", int'(cmd_valid), 0);
        check("reset_auto_en", int'(auto_en), 0);

        for (int i = 0; i < 16; i++) begin
            set_in(tv[i].iv, tv[i].btn, tv[i].cam, tv[i].org, tv[i].spd);
            tick();
            check($sformatf("vec%0d_state", i), int'(state), int'(tv[i].e_st));
            check($sformatf("vec%0d_dir", i), int'(motor_dir), int'(tv[i].e_dir));
            check($sformatf("vec%0d_speed", i), int'(motor_speed), int'(tv[i].e_spd));
            check($sformatf("vec%0d_cmd_valid", i), int'(cmd_valid), int'(tv[i].e_cv));
            check($sformatf("vec%0d_auto_en", i), int'(auto_en), int'(tv[i].e_auto));
        end

        // Manual hold lasts exactly MANUAL_HOLD cycles.
        do_reset();
        set_in(1'b1, 8'h02, 3'd0, 1'b0, 2'd2);
        tick();
        ir_valid = 1'b0;
        check("man_state", int'(state), SManual);
        check("man_dir", int'(motor_dir), 1);
        check("man_speed", int'(motor_speed), 2);
        check("man_cmd_valid", int'(cmd_valid), 1);
        for (int i = 1; i < ManHold; i++) begin
            tick();
            check($sformatf("man_hold%0d", i), int'(state), SManual);
        end
        tick();
        check("man_expire_state", int'(state), SIdle);
        check("man_expire_cmd_valid", int'(cmd_valid), 1);

        // Repeated movement code reloads the hold without a command strobe.
        do_reset();
        set_in(1'b1, 8'h02, 3'd0, 1'b0, 2'd2);
        tick();
        ir_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        check("reload_cmd_valid", int'(cmd_valid), 0);
        check("reload_dir", int'(motor_dir), 1);
        for (int i = 1; i < ManHold; i++) begin
            tick();
            check($sformatf("reload_hold%0d", i), int'(state), SManual);
        end
        tick();
        check("reload_expire", int'(state), SIdle);

        // Track, lose target, search window expiry, then STOP coinciding with expiry.
        do_reset();
        set_in(1'b1, 8'h01, 3'd3, 1'b1, 2'd2);
        tick();
        ir_valid = 1'b0;
        check("trk_state", int'(state), STrack);
        check("trk_dir", int'(motor_dir), 3);
        orange_detected = 1'b0;
        tick();
        check("srch_state", int'(state), SSearch);
        check("srch_dir", int'(motor_dir), 4);
        check("srch_speed", int'(motor_speed), 1);
        check("srch_cmd_valid", int'(cmd_valid), 1);
        for (int i = 1; i < LostHold; i++) begin
            tick();
            check($sformatf("srch_hold%0d", i), int'(state), SSearch);
        end
        tick();
        check("lost_state", int'(state), SIdle);
        check("lost_dir", int'(motor_dir), 0);
        check("lost_auto_en", int'(auto_en), 1);
        orange_detected = 1'b1;
        tick();
        check("idle_reacquire", int'(state), STrack);
        orange_detected = 1'b0;
        tick();
        for (int i = 1; i < LostHold; i++) tick();
        set_in(1'b1, 8'h05, 3'd3, 1'b0, 2'd2);
        tick();
        check("stop_vs_expiry_state", int'(state), SHalt);
        check("stop_vs_expiry_dir", int'(motor_dir), 0);
        check("stop_vs_expiry_speed", int'(motor_speed), 0);
        ir_button = 8'h03;
        tick();
        ir_valid = 1'b0;
        check("halt_ignores_03", int'(state), SHalt);
        check("halt_ignores_03_cv", int'(cmd_valid), 0);

        // Reset in the middle of a search.
        do_reset();
        set_in(1'b1, 8'h01, 3'd0, 1'b0, 2'd3);
        tick();
        ir_valid = 1'b0;
        check("pre_reset_search", int'(state), SSearch);
        tick();
        tick();
        reset = 1'b1;
        set_in(1'b1, 8'h02, 3'd0, 1'b0, 2'd3);
        tick();
        check("mid_reset_state", int'(state), SIdle);
        check("mid_reset_auto_en", int'(auto_en), 0);
        check("mid_reset_dir", int'(motor_dir), 0);
        check("mid_reset_speed", int'(motor_speed), 0);
        check("mid_reset_cmd_valid", int'(cmd_valid), 0);
        reset = 1'b0;
        ir_valid = 1'b0;
        tick();
        check("post_reset_state", int'(state), SIdle);
        check("post_reset_cmd_valid", int'(cmd_valid), 0);

        // Randomized run against the reference model.
        orange_detected = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            reset = (i < 2) || ($urandom_range(0, 299) == 0);
            ir_valid = ($urandom_range(0, 5) == 0);
            ir_button = codes[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) orange_detected = ~orange_detected;
            if ($urandom_range(0, 3) == 0) cam_direction = 3'($urandom_range(0, 7));
            speed = 2'($urandom_range(0, 3));
            model_step();
            tick();
            total++;
            if (int'(state) != m_st || int'(motor_dir) != m_dir || int'(motor_speed) != m_spd ||
                int'(cmd_valid) != m_cv || int'(auto_en) != m_auto) begin
                bad++;
                $display("FAIL rand%0d: got st=%0d dir=%0d spd=%0d cv=%0d auto=%0d, expected st=%0d dir=%0d spd=%0d cv=%0d auto=%0d",
                         i, state, motor_dir, motor_speed, cmd_valid, auto_en,
                         m_st, m_dir, m_spd, m_cv, m_auto);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
